// File: rtl/emb1_pkg.sv
// Shared constants and state encoding for the emb1 loader.
// VERIFY is only part of the encoding when EMB1_LOADER_READBACK_EN is defined.
package emb1_pkg;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 2048;
    localparam int LEN_W     = ADDR_W + 1;

`ifdef EMB1_LOADER_READBACK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/sram_v2.sv
// Single-port synchronous SRAM, active-low chip/write enables.
// A read (ceb=0, web=1) returns data on datao after the next rising edge.
module sram_v2 #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              ceb,
    input  logic              web,
    input  logic [DATA_W-1:0] datai,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] datao
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] datao_q;

    always_ff @(posedge clk) begin
        if (!ceb) begin
            if (!web) begin
                mem[addr] <= datai;
            end else begin
                datao_q <= mem[addr];
            end
        end
    end

    assign datao = datao_q;

endmodule

// File: rtl/emb1_loader.sv
// Streams len words into sram_v2 starting at base_addr, then serves consumer reads while idle.
// EMB1_LOADER_READBACK_EN adds an XOR-checksum readback pass (VERIFY) that flags err on mismatch.
module emb1_loader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    import emb1_pkg::*;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                rd_valid_q, rd_valid_d;

    logic                mem_ceb, mem_web;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_datai, mem_datao;

`ifdef EMB1_LOADER_READBACK_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic [DATA_W-1:0]   vsum_q, vsum_d;
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        mem_ceb    = 1'b1;
        mem_web    = 1'b1;
        mem_addr   = rd_addr;
        mem_datai  = wr_data;
`ifdef EMB1_LOADER_READBACK_EN
        csum_d     = csum_q;
        vsum_d     = vsum_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    len_d  = len;
                    cnt_d  = '0;
`ifdef EMB1_LOADER_READBACK_EN
                    csum_d = '0;
                    err_d  = 1'b0;
`endif
                    state_d = (len == '0) ? ST_DONE : ST_LOAD;
                end else if (rd_en) begin
                    mem_ceb    = 1'b0;
                    rd_valid_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (wr_valid) begin
                    mem_ceb  = 1'b0;
                    mem_web  = 1'b0;
                    mem_addr = base_q + cnt_q[ADDR_W-1:0];
                    cnt_d    = cnt_q + 1'b1;
`ifdef EMB1_LOADER_READBACK_EN
                    csum_d   = csum_q ^ wr_data;
                    if (cnt_d == len_q) begin
                        state_d = ST_VERIFY;
                        cnt_d   = '0;
                        vsum_d  = '0;
                    end
`else
                    if (cnt_d == len_q) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
`ifdef EMB1_LOADER_READBACK_EN
            // cnt_q counts issued reads; data for read k arrives while cnt_q == k+1
            ST_VERIFY: begin
                if (cnt_q != '0) begin
                    vsum_d = vsum_q ^ mem_datao;
                end
                if (cnt_q != len_q) begin
                    mem_ceb  = 1'b0;
                    mem_addr = base_q + cnt_q[ADDR_W-1:0];
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    state_d = ST_DONE;
                    if (vsum_d != csum_q) begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
`ifdef EMB1_LOADER_READBACK_EN
            csum_q     <= '0;
            vsum_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
`ifdef EMB1_LOADER_READBACK_EN
            csum_q     <= csum_d;
            vsum_q     <= vsum_d;
            err_q      <= err_d;
`endif
        end
    end

    sram_v2 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk   (clk),
        .ceb   (mem_ceb),
        .web   (mem_web),
        .datai (mem_datai),
        .addr  (mem_addr),
        .datao (mem_datao)
    );

    assign wr_ready = (state_q == ST_LOAD);
    assign done     = (state_q == ST_DONE);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? mem_datao : '0;
`ifdef EMB1_LOADER_READBACK_EN
    assign busy     = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
    assign err      = err_q;
`else
    assign busy     = (state_q == ST_LOAD);
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_emb1_loader.sv
// Directed bench for emb1_loader; readback scenarios run when EMB1_LOADER_READBACK_EN is defined.
module tb_emb1_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [11:0] len;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready, busy, done, err;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    int n_cmp = 0;
    int n_err = 0;

`ifdef EMB1_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    emb1_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input int n);
        return RB ? n + 1 : 0;
    endfunction

    task automatic do_start(input logic [10:0] b, input logic [11:0] n);
        start     = 1'b1;
        base_addr = b;
        len       = n;
        step();
        start     = 1'b0;
    endtask

    task automatic do_read(input logic [10:0] a, output logic v, output logic [31:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        v       = rd_valid;
        d       = rd_data;
    endtask

    // steps until done is seen, bounded; returns steps taken (-1 on timeout)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({wr_ready, busy, done, err, rd_valid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags got=%b want=00000", {wr_ready, busy, done, err, rd_valid});
        end
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rd_data got=%h want=0", rd_data);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_load();
        int lat;
        logic v;
        logic [31:0] d;
        do_start(11'd0, 12'd4);
        n_cmp++;
        if ({busy, wr_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL load_enter got busy,wr_ready=%b want=11", {busy, wr_ready});
        end
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA0 + i;
            #1;
            n_cmp++;
            if ({dut.mem_ceb, dut.mem_web, dut.mem_addr} !== {2'b00, 11'(i)}) begin
                n_err++;
                $display("FAIL load_write%0d got ceb,web=%b%b addr=%0d want 00 addr=%0d",
                         i, dut.mem_ceb, dut.mem_web, dut.mem_addr, i);
            end
            step();
        end
        wr_valid = 1'b0;
        wait_done(lat);
        n_cmp++;
        if (lat !== exp_lat(4)) begin
            n_err++;
            $display("FAIL load_done_latency got=%0d want=%0d", lat, exp_lat(4));
        end
        n_cmp++;
        if ({busy, err} !== 2'b00) begin
            n_err++;
            $display("FAIL load_done_flags got busy,err=%b want=00", {busy, err});
        end
        step();
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL load_back_idle got done,busy=%b want=00", {done, busy});
        end
        for (int i = 0; i < 4; i++) begin
            do_read(11'(i), v, d);
            n_cmp++;
            if ({v, d} !== {1'b1, 32'hA0 + i}) begin
                n_err++;
                $display("FAIL load_read%0d got v=%b d=%h want v=1 d=%h", i, v, d, 32'hA0 + i);
            end
        end
        step();
    endtask

    task automatic test_wrap();
        int lat;
        logic v;
        logic [31:0] d;
        logic [10:0] exp_a [3];
        exp_a[0] = 11'd2046;
        exp_a[1] = 11'd2047;
        exp_a[2] = 11'd0;
        do_start(11'd2046, 12'd3);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'h5500 + i;
            #1;
            n_cmp++;
            if ({dut.mem_ceb, dut.mem_web, dut.mem_addr} !== {2'b00, exp_a[i]}) begin
                n_err++;
                $display("FAIL wrap_write%0d got addr=%0d ceb=%b want addr=%0d ceb=0",
                         i, dut.mem_addr, dut.mem_ceb, exp_a[i]);
            end
            step();
        end
        wr_valid = 1'b0;
        wait_done(lat);
        n_cmp++;
        if (lat !== exp_lat(3)) begin
            n_err++;
            $display("FAIL wrap_done_latency got=%0d want=%0d", lat, exp_lat(3));
        end
        step();
        do_read(11'd0, v, d);
        n_cmp++;
        if ({v, d} !== {1'b1, 32'h5502}) begin
            n_err++;
            $display("FAIL wrap_read0 got v=%b d=%h want v=1 d=00005502", v, d);
        end
        do_read(11'd2047, v, d);
        n_cmp++;
        if ({v, d} !== {1'b1, 32'h5501}) begin
            n_err++;
            $display("FAIL wrap_read2047 got v=%b d=%h want v=1 d=00005501", v, d);
        end
        step();
    endtask

    task automatic test_backpressure();
        int lat;
        int widx;
        logic v;
        logic [31:0] d;
        logic pat [5];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
        widx = 0;
        do_start(11'd100, 12'd3);
        for (int k = 0; k < 5; k++) begin
            wr_valid = pat[k];
            wr_data  = 32'hB0 + k;
            if (k == 1) begin
                start     = 1'b1;
                base_addr = 11'd500;
                len       = 12'd5;
            end
            #1;
            n_cmp++;
            if (dut.mem_ceb !== !pat[k] || wr_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_cycle%0d got ceb=%b wr_ready=%b want ceb=%b wr_ready=1",
                         k, dut.mem_ceb, wr_ready, !pat[k]);
            end
            if (pat[k]) begin
                n_cmp++;
                if (dut.mem_addr !== 11'(100 + widx)) begin
                    n_err++;
                    $display("FAIL bp_addr%0d got=%0d want=%0d", k, dut.mem_addr, 100 + widx);
                end
                widx++;
            end
            step();
            start = 1'b0;
        end
        wr_valid = 1'b0;
        wait_done(lat);
        n_cmp++;
        if (lat !== exp_lat(3)) begin
            n_err++;
            $display("FAIL bp_busy_start_ignored got latency=%0d want=%0d", lat, exp_lat(3));
        end
        step();
        do_read(11'd101, v, d);
        n_cmp++;
        if ({v, d} !== {1'b1, 32'hB2}) begin
            n_err++;
            $display("FAIL bp_read101 got v=%b d=%h want v=1 d=000000b2", v, d);
        end
        step();
    endtask

    task automatic test_collision_len0();
        start     = 1'b1;
        base_addr = 11'd7;
        len       = 12'd0;
        rd_en     = 1'b1;
        rd_addr   = 11'd0;
        #1;
        n_cmp++;
        if ({dut.mem_ceb, dut.mem_web} !== 2'b11) begin
            n_err++;
            $display("FAIL len0_no_access got ceb,web=%b want=11", {dut.mem_ceb, dut.mem_web});
        end
        step();
        start = 1'b0;
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL collision_rd_valid got=%b want=0", rd_valid);
        end
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL len0_done got done,busy=%b want=10", {done, busy});
        end
        step();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL len0_done_single got=%b want=0", done);
        end
    endtask

    task automatic test_reset_mid_load();
        logic v;
        logic [31:0] d;
        logic saw_done;
        do_start(11'd200, 12'd8);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hC0 + i;
            step();
        end
        wr_data = 32'hC2;
        reset   = 1'b1;
        step();
        reset    = 1'b0;
        wr_valid = 1'b0;
        n_cmp++;
        if ({busy, done, wr_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_mid_flags got busy,done,wr_ready=%b want=000", {busy, done, wr_ready});
        end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_no_done got done seen=%b want=0", saw_done);
        end
        do_read(11'd200, v, d);
        n_cmp++;
        if ({v, d} !== {1'b1, 32'hC0}) begin
            n_err++;
            $display("FAIL rst_mid_read200 got v=%b d=%h want v=1 d=000000c0", v, d);
        end
        do_read(11'd201, v, d);
        n_cmp++;
        if ({v, d} !== {1'b1, 32'hC1}) begin
            n_err++;
            $display("FAIL rst_mid_read201 got v=%b d=%h want v=1 d=000000c1", v, d);
        end
        step();
    endtask

`ifdef EMB1_LOADER_READBACK_EN
    task automatic test_readback();
        int lat;
        do_start(11'd300, 12'd4);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hD0 + i;
            step();
        end
        wr_valid = 1'b0;
        wait_done(lat);
        n_cmp++;
        if (lat !== 5 || err !== 1'b0) begin
            n_err++;
            $display("FAIL rb_clean got latency=%0d err=%b want latency=5 err=0", lat, err);
        end
        step();
        do_start(11'd300, 12'd4);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hD0 + i;
            step();
        end
        wr_valid = 1'b0;
        dut.u_sram.mem[301] = dut.u_sram.mem[301] ^ 32'h0000_0100;
        wait_done(lat);
        n_cmp++;
        if (lat !== 5 || err !== 1'b1) begin
            n_err++;
            $display("FAIL rb_corrupt got latency=%0d err=%b want latency=5 err=1", lat, err);
        end
        step();
        step();
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL rb_err_sticky got=%b want=1", err);
        end
        do_start(11'd0, 12'd0);
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL rb_err_clear_on_start got=%b want=0", err);
        end
        step();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        test_reset();
        test_load();
        test_wrap();
        test_backpressure();
        test_collision_len0();
        test_reset_mid_load();
`ifdef EMB1_LOADER_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
